// File: rtl/simon_playback_ctrl.sv
// Simon playback sequencer: reseeds the pattern generator and replays `score` lights with
// fixed on/off dwell times, pulsing done when the whole pattern has been shown.
module simon_playback_ctrl #(
    parameter int unsigned SEQW      = 8,
    parameter int unsigned TW        = 6,
    parameter int unsigned ON_TICKS  = 4,
    parameter int unsigned OFF_TICKS = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [SEQW-1:0] score_i,
    input  logic [7:0]      rnd_i,
    output logic            poly_rst_o,
    output logic            poly_en_o,
    output logic [3:0]      led_o,
    output logic [SEQW-1:0] seq_idx_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [2:0] {StIdle, StReseed, StOn, StOff, StFin} state_e;

    localparam logic [TW-1:0] OnLoad  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OffLoad = TW'(OFF_TICKS - 1);

    state_e          state_q, state_d;
    logic [SEQW-1:0] len_q, len_d;
    logic [SEQW-1:0] idx_q, idx_d;
    logic [TW-1:0]   dwell_q, dwell_d;
    logic            last_step;
    logic            unused_rnd;

    assign unused_rnd = ^rnd_i[7:2];
    // Extra bit keeps idx+1 from wrapping when len is all ones.
    assign last_step  = ({1'b0, idx_q} + 1'b1) == {1'b0, len_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        len_d   = score_i;
                        idx_d   = '0;
                        state_d = StReseed;
                    end
                end
                StReseed: begin
                    if (len_q == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StOn;
                        dwell_d = OnLoad;
                    end
                end
                StOn: begin
                    if (dwell_q == '0) begin
                        state_d = StOff;
                        dwell_d = OffLoad;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                StOff: begin
                    if (dwell_q == '0) begin
                        idx_d = idx_q + 1'b1;
                        if (last_step) begin
                            state_d = StFin;
                        end else begin
                            state_d = StOn;
                            dwell_d = OnLoad;
                        end
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                StFin:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Abort silences every output in the cycle it is seen.
    always_comb begin
        poly_rst_o = 1'b0;
        poly_en_o  = 1'b0;
        led_o      = 4'b0000;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        if (!abort_i) begin
            unique case (state_q)
                StReseed: begin
                    poly_rst_o = 1'b1;
                    busy_o     = 1'b1;
                end
                StOn: begin
                    led_o  = 4'b0001 << rnd_i[1:0];
                    busy_o = 1'b1;
                end
                StOff: begin
                    busy_o    = 1'b1;
                    poly_en_o = (dwell_q == '0);
                end
                StFin:   done_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign seq_idx_o = idx_q;

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Directed bench for simon_playback_ctrl with a counting model of the poly generator
// (reseed to 0x01, +1 per advance).
module tb_simon_playback_ctrl;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       start, abort;
    logic [7:0] score, rnd;
    logic       poly_rst, poly_en, busy, done;
    logic [3:0] led;
    logic [7:0] seq_idx;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] obs, expv;
    logic [3:0] exp_led;

    simon_playback_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start),
        .abort_i    (abort),
        .score_i    (score),
        .rnd_i      (rnd),
        .poly_rst_o (poly_rst),
        .poly_en_o  (poly_en),
        .led_o      (led),
        .seq_idx_o  (seq_idx),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    initial rnd = 8'h00;
    always_ff @(posedge clk) begin
        if (poly_rst)     rnd <= 8'h01;
        else if (poly_en) rnd <= rnd + 8'h01;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start = 1'b0; abort = 1'b0; score = 8'd0;
        #3;
        n_vec++;
        if ({poly_rst, poly_en, busy, done, led, seq_idx} !== 16'h0) begin
            n_err++;
            $display("FAIL reset: outs=%h seq_idx=%0d want all 0", {poly_rst, poly_en, busy, done, led},
                     seq_idx);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        score = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            exp_led = (c >= 2 && c <= 5) ? 4'b0010 : (c >= 8 && c <= 11) ? 4'b0100 :
                      (c >= 14 && c <= 17) ? 4'b1000 : 4'b0000;
            expv = {c == 1, c == 7 || c == 13 || c == 19, c <= 19, c == 20, exp_led};
            obs  = {poly_rst, poly_en, busy, done, led};
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL basic c=%0d: rst/en/busy/done/led=%b want %b", c, obs, expv);
            end
            if (c >= 2 && c <= 19) begin
                n_vec++;
                if (seq_idx !== 8'((c - 2) / 6)) begin
                    n_err++;
                    $display("FAIL basic_idx c=%0d: seq_idx=%0d want %0d", c, seq_idx, (c - 2) / 6);
                end
            end
            if (c < 21) tick();
        end
    endtask

    task automatic test_zero_len();
        score = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            expv = {c == 1, 1'b0, c == 1, c == 2, 4'b0000};
            obs  = {poly_rst, poly_en, busy, done, led};
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL zero_len c=%0d: rst/en/busy/done/led=%b want %b", c, obs, expv);
            end
            if (c < 3) tick();
        end
    endtask

    // Second start is raised during FIN, so it is accepted only from IDLE one cycle later.
    task automatic test_back_to_back();
        score = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 14; c++) begin
                exp_led = (c >= 2 && c <= 5) ? 4'b0010 : (c >= 8 && c <= 11) ? 4'b0100 : 4'b0000;
                expv = {c == 1, c == 7 || c == 13, c <= 13, c == 14, exp_led};
                obs  = {poly_rst, poly_en, busy, done, led};
                n_vec++;
                if (obs !== expv) begin
                    n_err++;
                    $display("FAIL back_to_back r=%0d c=%0d: outs=%b want %b", r, c, obs, expv);
                end
                if (c < 14) tick();
            end
            if (r == 0) begin
                start = 1'b1;
                tick();
                n_vec++;
                if ({poly_rst, busy, done} !== 3'b000) begin
                    n_err++;
                    $display("FAIL fin_start: rst/busy/done=%b want 000", {poly_rst, busy, done});
                end
                tick();
                start = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_abort();
        score = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        n_vec++;
        if ({led, seq_idx} !== {4'b0100, 8'd1}) begin
            n_err++;
            $display("FAIL abort_pre: led=%b idx=%0d want 0100 1", led, seq_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            obs = {poly_rst, poly_en, busy, done, led};
            n_vec++;
            if (obs !== 8'h00) begin
                n_err++;
                $display("FAIL abort_after k=%0d: outs=%b want 00000000", k, obs);
            end
            tick();
        end
        score = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_led = (c >= 2 && c <= 5) ? 4'b0010 : 4'b0000;
            expv = {c == 1, c == 7, c <= 7, c == 8, exp_led};
            obs  = {poly_rst, poly_en, busy, done, led};
            n_vec++;
            if (obs !== expv || (c == 2 && seq_idx !== 8'd0)) begin
                n_err++;
                $display("FAIL abort_replay c=%0d: outs=%b idx=%0d want %b idx 0", c, obs, seq_idx,
                         expv);
            end
            if (c < 8) tick();
        end
        tick();
    endtask

    task automatic test_ignored_start();
        score = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            n_vec++;
            if ({poly_rst, busy, done} !== {c == 1, c <= 19, c == 20}) begin
                n_err++;
                $display("FAIL ignored_start c=%0d: rst/busy/done=%b want %b", c,
                         {poly_rst, busy, done}, {c == 1, c <= 19, c == 20});
            end
            if (c == 4 || c == 12) start = 1'b1;
            if (c == 5 || c == 13) start = 1'b0;
            if (c == 6) score = 8'd9;
            if (c < 21) tick();
        end
    endtask

    task automatic test_async_reset();
        score = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        n_vec++;
        if ({poly_en, busy, led} !== 6'b110000) begin
            n_err++;
            $display("FAIL async_pre: en/busy/led=%b want 110000", {poly_en, busy, led});
        end
        #2;
        rst_ni = 1'b0;
        #1;
        obs = {poly_rst, poly_en, busy, done, led};
        n_vec++;
        if (obs !== 8'h00 || seq_idx !== 8'd0) begin
            n_err++;
            $display("FAIL async_rst: outs=%b idx=%0d want 00000000 idx 0", obs, seq_idx);
        end
        #2;
        rst_ni = 1'b1;
        tick();
        obs = {poly_rst, poly_en, busy, done, led};
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL async_idle: outs=%b want 00000000", obs);
        end
        score = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if ({poly_rst, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL async_restart: rst/busy=%b want 11", {poly_rst, busy});
        end
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL async_done: done=%b want 1", done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_back_to_back();
        test_abort();
        test_ignored_start();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
